// File: rtl/hack_ctrl.sv
// ============================================================================
// hack_ctrl : multi-cycle Hack CPU controller (fetch / exec) driving an external ALU
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hack_ctrl #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] pc_o,
   input  logic [DATA_W-1:0] instr_i,
   input  logic              instr_vld_i,
   output logic [DATA_W-1:0] alu_x_o,
   output logic [DATA_W-1:0] alu_y_o,
   output logic              alu_zx_o,
   output logic              alu_nx_o,
   output logic              alu_zy_o,
   output logic              alu_ny_o,
   output logic              alu_f_o,
   output logic              alu_no_o,
   input  logic [DATA_W-1:0] alu_out_i,
   input  logic              alu_zr_i,
   input  logic              alu_ng_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_we_o,
   output logic              instr_done_o,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] d_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] d_reg;
   logic [DATA_W-1:0] ir;
   logic [5:0]        alu_ctl;
   logic              mem_we;
   logic              instr_req;
   logic              instr_done;

   logic              jump_taken;
   logic [ADDR_W-1:0] pc_inc;

   assign jump_taken = (ir[2] & alu_ng_i) | (ir[1] & alu_zr_i) |
                       (ir[0] & ~alu_ng_i & ~alu_zr_i);
   assign pc_inc     = pc + ADDR_W'(1);

   // Controls and write strobe are registered from instr_i at accept time,
   // so they are valid for exactly the EXEC cycle and never combinational from instr_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         pc         <= '0;
         a_reg      <= '0;
         d_reg      <= '0;
         ir         <= '0;
         alu_ctl    <= '0;
         mem_we     <= 1'b0;
         instr_req  <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state     <= FETCH;
               instr_req <= 1'b1;
            end
            FETCH: begin
               if (instr_vld_i) begin
                  ir         <= instr_i;
                  state      <= EXEC;
                  instr_req  <= 1'b0;
                  instr_done <= 1'b1;
                  alu_ctl    <= instr_i[15] ? instr_i[11:6] : 6'b0;
                  mem_we     <= instr_i[15] & instr_i[3];
               end
            end
            EXEC: begin
               state      <= FETCH;
               instr_req  <= 1'b1;
               instr_done <= 1'b0;
               alu_ctl    <= '0;
               mem_we     <= 1'b0;
               if (!ir[15]) begin
                  a_reg <= {1'b0, ir[DATA_W-2:0]};
                  pc    <= pc_inc;
               end else begin
                  // Jump target uses A before any same-cycle A write.
                  if (ir[5]) a_reg <= alu_out_i;
                  if (ir[4]) d_reg <= alu_out_i;
                  pc <= jump_taken ? a_reg[ADDR_W-1:0] : pc_inc;
               end
            end
            default: begin
               state      <= IDLE;
               instr_req  <= 1'b0;
               instr_done <= 1'b0;
               alu_ctl    <= '0;
               mem_we     <= 1'b0;
            end
         endcase
      end
   end

   assign instr_req_o  = instr_req;
   assign pc_o         = pc;
   assign alu_x_o      = d_reg;
   assign alu_y_o      = ir[12] ? mem_rdata_i : a_reg;
   assign alu_zx_o     = alu_ctl[5];
   assign alu_nx_o     = alu_ctl[4];
   assign alu_zy_o     = alu_ctl[3];
   assign alu_ny_o     = alu_ctl[2];
   assign alu_f_o      = alu_ctl[1];
   assign alu_no_o     = alu_ctl[0];
   assign mem_addr_o   = a_reg[ADDR_W-1:0];
   assign mem_wdata_o  = alu_out_i;
   assign mem_we_o     = mem_we;
   assign instr_done_o = instr_done;
   assign a_o          = a_reg;
   assign d_o          = d_reg;

endmodule

`default_nettype wire

// File: tb/tb_hack_ctrl.sv
// Testbench for hack_ctrl: Hack-ISA reference model with scoreboard, directed and random programs.
`default_nettype none

module tb_hack_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        instr_req_o;
   logic [14:0] pc_o;
   logic [15:0] instr_i = '0;
   logic        instr_vld_i = 1'b0;
   logic [15:0] alu_x_o, alu_y_o, alu_out_i, mem_rdata_i, mem_wdata_o, a_o, d_o;
   logic        alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o;
   logic        alu_zr_i, alu_ng_i, mem_we_o, instr_done_o;
   logic [14:0] mem_addr_o;

   hack_ctrl #(.ADDR_W(15), .DATA_W(16)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_req_o(instr_req_o), .pc_o(pc_o),
      .instr_i(instr_i), .instr_vld_i(instr_vld_i), .alu_x_o(alu_x_o), .alu_y_o(alu_y_o),
      .alu_zx_o(alu_zx_o), .alu_nx_o(alu_nx_o), .alu_zy_o(alu_zy_o), .alu_ny_o(alu_ny_o),
      .alu_f_o(alu_f_o), .alu_no_o(alu_no_o), .alu_out_i(alu_out_i), .alu_zr_i(alu_zr_i),
      .alu_ng_i(alu_ng_i), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
      .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .instr_done_o(instr_done_o),
      .a_o(a_o), .d_o(d_o));

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Hack ALU, used both as the environment ALU and inside the reference model.
   function automatic logic [15:0] hack_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
      logic [15:0] xx, yy, o;
      xx = c[5] ? 16'h0 : x;
      xx = c[4] ? ~xx : xx;
      yy = c[3] ? 16'h0 : y;
      yy = c[2] ? ~yy : yy;
      o  = c[1] ? (xx + yy) : (xx & yy);
      return c[0] ? ~o : o;
   endfunction

   logic [15:0] ram  [0:32767];
   logic [15:0] mram [0:32767];

   assign mem_rdata_i = ram[mem_addr_o];
   assign alu_out_i   = hack_alu({alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o}, alu_x_o, alu_y_o);
   assign alu_zr_i    = (alu_out_i == 16'h0);
   assign alu_ng_i    = alu_out_i[15];

   always @(posedge clk_i) if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, expv);
      end
   endtask

   typedef struct {
      logic [5:0]  ctl;
      logic        we;
      logic [14:0] addr;
      logic [15:0] wdata;
      logic [14:0] pc_pre;
      logic [14:0] pc_post;
      logic [15:0] a_post;
      logic [15:0] d_post;
   } exp_t;

   exp_t q[$];

   // Architectural reference state
   logic [14:0] m_pc = '0;
   logic [15:0] m_a = '0, m_d = '0;
   logic [14:0] undo_addr = '0;
   logic [15:0] undo_val = '0;

   task automatic model_issue(input logic [15:0] ins);
      exp_t e;
      logic [15:0] y, o;
      logic taken;
      e.pc_pre = m_pc;
      e.addr   = m_a[14:0];
      e.wdata  = '0;
      undo_addr = m_a[14:0];
      undo_val  = mram[m_a[14:0]];
      if (ins[15] == 1'b0) begin
         e.ctl = '0;
         e.we  = 1'b0;
         m_a   = {1'b0, ins[14:0]};
         m_pc  = m_pc + 15'd1;
      end else begin
         y     = ins[12] ? mram[m_a[14:0]] : m_a;
         o     = hack_alu(ins[11:6], m_d, y);
         taken = (ins[2] && $signed(o) < 0) || (ins[1] && o == 0) || (ins[0] && $signed(o) > 0);
         e.ctl   = ins[11:6];
         e.we    = ins[3];
         e.wdata = o;
         if (ins[3]) mram[m_a[14:0]] = o;
         m_pc = taken ? m_a[14:0] : m_pc + 15'd1;
         if (ins[5]) m_a = o;
         if (ins[4]) m_d = o;
      end
      e.pc_post = m_pc;
      e.a_post  = m_a;
      e.d_post  = m_d;
      q.push_back(e);
   endtask

   // Monitor / scoreboard
   exp_t pend;
   bit   pending = 0;
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         pending = 0;
         q.delete();
      end else begin
         if (pending) begin
            chk("post_a", a_o, pend.a_post);
            chk("post_d", d_o, pend.d_post);
            chk("post_pc", pc_o, pend.pc_post);
            pending = 0;
         end
         if (!instr_done_o) begin
            chk("idle_we", mem_we_o, 1'b0);
            chk("idle_ctl", {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o}, 6'b0);
         end else if (q.size() == 0) begin
            chk("unexpected_retire", 1, 0);
         end else begin
            pend = q.pop_front();
            chk("exec_ctl", {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o}, pend.ctl);
            chk("exec_we", mem_we_o, pend.we);
            chk("exec_addr", mem_addr_o, pend.addr);
            chk("exec_pc", pc_o, pend.pc_pre);
            if (pend.we) chk("exec_wdata", mem_wdata_o, pend.wdata);
            pending = 1;
         end
      end
   end

   task automatic wait_fetch();
      int guard = 0;
      while (!instr_req_o && guard < 20) begin
         @(negedge clk_i);
         guard++;
      end
      if (!instr_req_o) chk("fetch_timeout", 0, 1);
   endtask

   task automatic issue(input logic [15:0] ins, input int stall);
      logic [14:0] pc0;
      wait_fetch();
      pc0 = pc_o;
      for (int s = 0; s < stall; s++) begin
         instr_vld_i = 1'b0;
         instr_i     = 16'($urandom);
         @(negedge clk_i);
      end
      if (stall > 0) begin
         chk("stall_pc", pc_o, pc0);
         chk("stall_req", instr_req_o, 1'b1);
      end
      instr_vld_i = 1'b1;
      instr_i     = ins;
      model_issue(ins);
      @(negedge clk_i);
      instr_vld_i = 1'b0;
      instr_i     = 16'($urandom);
   endtask

   task automatic reset_model();
      m_pc = '0;
      m_a  = '0;
      m_d  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, instr_req_o, 1'b0);
      chk({tag, "_we"}, mem_we_o, 1'b0);
      chk({tag, "_done"}, instr_done_o, 1'b0);
      chk({tag, "_ctl"}, {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o}, 6'b0);
      chk({tag, "_pc"}, pc_o, 15'd0);
      chk({tag, "_a"}, a_o, 16'd0);
      chk({tag, "_d"}, d_o, 16'd0);
   endtask

   task automatic release_reset();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("idle_req", instr_req_o, 1'b0);
      @(negedge clk_i);
      chk("fetch_req", instr_req_o, 1'b1);
      chk("fetch_pc0", pc_o, 15'd0);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 9) < 4) begin
         if ($urandom_range(0, 1) == 0) r = 16'($urandom_range(0, 31));
         r[15] = 1'b0;
      end else begin
         r[15] = 1'b1;
      end
      return r;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      for (int i = 0; i < 32768; i++) begin
         v = 16'($urandom);
         ram[i]  = v;
         mram[i] = v;
      end
      repeat (3) @(negedge clk_i);
      check_reset_outputs("rst0");
      release_reset();

      // Arithmetic sequence
      issue(16'h0011, 0);
      issue(16'hEC10, 0);
      issue(16'h0003, 0);
      issue(16'hE090, 0);
      @(negedge clk_i);
      chk("arith_d", d_o, 16'h0014);
      chk("arith_a", a_o, 16'h0003);
      chk("arith_pc", pc_o, 15'd4);

      // Memory write M=D
      issue(16'h0064, 0);
      issue(16'hE308, 0);
      @(negedge clk_i);
      chk("memw_ram", ram[100], 16'h0014);
      chk("memw_d", d_o, 16'h0014);

      // Jumps
      issue(16'h0008, 0);
      issue(16'hE301, 0);
      @(negedge clk_i);
      chk("jgt_taken_pc", pc_o, 15'd8);
      issue(16'h0000, 0);
      issue(16'hEC10, 0);
      issue(16'h0008, 0);
      issue(16'hE301, 0);
      @(negedge clk_i);
      chk("jgt_nottaken_pc", pc_o, 15'd12);
      issue(16'h0008, 0);
      issue(16'hE302, 0);
      @(negedge clk_i);
      chk("jeq_taken_pc", pc_o, 15'd8);

      // Stall then PC wrap
      issue(16'h7FFF, 5);
      issue(16'hE307, 0);
      @(negedge clk_i);
      chk("wrap_pc_max", pc_o, 15'h7FFF);
      issue(16'h0001, 0);
      @(negedge clk_i);
      chk("wrap_pc_zero", pc_o, 15'd0);

      // Simultaneous destination A=D+A
      issue(16'h0003, 0);
      issue(16'hEC10, 0);
      issue(16'h0005, 0);
      issue(16'hE0A0, 0);
      @(negedge clk_i);
      chk("simul_a", a_o, 16'h0008);

      // Randomized program
      for (int n = 0; n < 300; n++) issue(rand_instr(), $urandom_range(0, 3));

      // Reset in the middle of an M-writing EXEC
      issue(16'h0064, 0);
      wait_fetch();
      instr_vld_i = 1'b1;
      instr_i     = 16'hE3C8;
      model_issue(16'hE3C8);
      @(posedge clk_i);
      #1;
      instr_vld_i = 1'b0;
      #1;
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("rst1");
      mram[undo_addr] = undo_val;
      reset_model();
      @(posedge clk_i);
      #1;
      chk("abort_no_write", ram[100], mram[100]);
      repeat (2) @(negedge clk_i);
      release_reset();
      issue(16'h0002, 1);
      issue(16'hEC10, 0);
      @(negedge clk_i);
      chk("post_rst_d", d_o, 16'h0002);

      repeat (2) @(negedge clk_i);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
